// File: rtl/mfsm_pkg.sv
// ---------------------------------------------------------------------------
// mfsm_pkg
//  Shared definitions for the multi-cycle RV32I main control FSM:
//  RV32I opcode constants, the FSM state enumeration, the datapath mux
//  select encodings and the packed control vector that the output decoder
//  produces. Also holds two helpers for decoding the opcode: the immediate
//  format select and a recognised-opcode test.
// ---------------------------------------------------------------------------
package mfsm_pkg;

    // RV32I major opcodes (instruction[6:0])
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_I_AL   = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_REG    = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALUSrcA encodings
    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;
    localparam logic [1:0] A_ZERO  = 2'b11;

    // ALUSrcB encodings
    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ImmSrc encodings
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_JALR_EX,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    // Per-cycle control vector (everything except ImmSrc, which is a pure
    // function of the opcode and therefore lives outside the state table).
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    // Immediate format implied by the opcode; REG and unknown opcodes give I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] imm;
        imm = IMM_I;
        case (op)
            OP_STORE:         imm = IMM_S;
            OP_BRANCH:        imm = IMM_B;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            OP_JAL:           imm = IMM_J;
            default:          imm = IMM_I;
        endcase
        return imm;
    endfunction

    function automatic logic op_known(input logic [6:0] op);
        logic known;
        known = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_REG, OP_I_AL, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: known = 1'b1;
            default:                           known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/main_fsm_dec_if.sv
// ---------------------------------------------------------------------------
// main_fsm_dec_if
//  Bundle between the main control FSM and the multi-cycle datapath.
//  master : FSM side   - receives Op, Zero, mem_ready; drives all controls
//  slave  : datapath   - drives Op, Zero, mem_ready; receives all controls
//  Optional macro MFSM_ILLEGAL_TRAP_EN adds the illegal_op status line.
// ---------------------------------------------------------------------------
interface main_fsm_dec_if;
    logic [6:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       instr_done;
`ifdef MFSM_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    modport master (
        input  Op, Zero, mem_ready,
`ifdef MFSM_ILLEGAL_TRAP_EN
        output illegal_op,
`endif
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done
    );

    modport slave (
        output Op, Zero, mem_ready,
`ifdef MFSM_ILLEGAL_TRAP_EN
        input  illegal_op,
`endif
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done
    );
endinterface

// File: rtl/mfsm_out_dec.sv
// ---------------------------------------------------------------------------
// mfsm_out_dec
//  Combinational state -> control vector table for the main FSM.
//  Moore per state, except the few strobes that are qualified by an input:
//  PCWrite/IRWrite in FETCH (mem_ready), PCWrite in BEQ (Zero), instr_done
//  in MEMWRITE (mem_ready) and in DECODE for an unrecognised opcode.
//  Ports:
//   state_i      current FSM state
//   zero_i       ALU zero flag
//   mem_ready_i  memory completes its access this cycle
//   nop_done_i   DECODE is retiring an unknown opcode as a NOP
//   ctrl_o       control vector (all zero in TRAP and unlisted states)
// ---------------------------------------------------------------------------
module mfsm_out_dec
    import mfsm_pkg::*;
(
    input  state_t state_i,
    input  logic   zero_i,
    input  logic   mem_ready_i,
    input  logic   nop_done_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.alu_src_a  = A_PC;
                ctrl_o.alu_src_b  = B_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALURES;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_write   = mem_ready_i;
            end
            S_DECODE: begin
                // Precompute OldPC + imm for branch / JAL targets.
                ctrl_o.alu_src_a  = A_OLDPC;
                ctrl_o.alu_src_b  = B_IMM;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.instr_done = nop_done_i;
            end
            S_MEMADR, S_JALR_EX: begin
                ctrl_o.alu_src_a = A_RS1;
                ctrl_o.alu_src_b = B_IMM;
            end
            S_MEMREAD: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_MEM;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXECR: begin
                ctrl_o.alu_src_a = A_RS1;
                ctrl_o.alu_src_b = B_RS2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl_o.alu_src_a = A_RS1;
                ctrl_o.alu_src_b = B_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a  = A_RS1;
                ctrl_o.alu_src_b  = B_RS2;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_write   = zero_i;
                ctrl_o.instr_done = 1'b1;
            end
            S_JAL: begin
                // PC <= target held in ALUOut; ALU forms OldPC+4 for rd.
                ctrl_o.alu_src_a  = A_OLDPC;
                ctrl_o.alu_src_b  = B_FOUR;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_write   = 1'b1;
            end
            S_LUI: begin
                ctrl_o.alu_src_a = A_ZERO;
                ctrl_o.alu_src_b = B_IMM;
            end
            S_AUIPC: begin
                ctrl_o.alu_src_a = A_OLDPC;
                ctrl_o.alu_src_b = B_IMM;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/main_fsm_dec.sv
// ---------------------------------------------------------------------------
// main_fsm_dec
//  Multi-cycle main control FSM for the RV32I core. Steps
//  FETCH -> DECODE -> execute states -> FETCH using Op from the held
//  instruction register, stalling on mem_ready in FETCH/MEMREAD/MEMWRITE.
//  Owns the state register, next-state logic and the ImmSrc decode; the
//  per-state control table lives in mfsm_out_dec.
//  Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset; forces every output to 0 while high
//   bus  main_fsm_dec_if.master (Op/Zero/mem_ready in, controls out)
//  Optional macro MFSM_ILLEGAL_TRAP_EN: unknown opcodes enter a TRAP state
//  that holds illegal_op=1 until reset instead of retiring as a NOP.
// ---------------------------------------------------------------------------
module main_fsm_dec
    import mfsm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    main_fsm_dec_if.master bus
);

    state_t state_q, state_d;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl_out;
    logic [2:0] imm_out;
    logic   nop_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXECR;
                    OP_I_AL:           state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_EX;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
`ifdef MFSM_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            // Op is still held from DECODE, so it selects load vs store.
            S_MEMADR: begin
                if (bus.Op == OP_STORE) begin
                    state_d = S_MEMWRITE;
                end else if (bus.Op == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR_EX:  state_d = S_JAL;
`ifdef MFSM_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // An unknown opcode retires in DECODE only when it is treated as a NOP.
`ifdef MFSM_ILLEGAL_TRAP_EN
    assign nop_done = 1'b0;
`else
    assign nop_done = (state_q == S_DECODE) && !op_known(bus.Op);
`endif

    mfsm_out_dec u_out_dec (
        .state_i     (state_q),
        .zero_i      (bus.Zero),
        .mem_ready_i (bus.mem_ready),
        .nop_done_i  (nop_done),
        .ctrl_o      (ctrl_raw)
    );

    // Gate everything with rst so no strobe (especially RegWrite/MemWrite
    // from an aborted instruction) escapes during the reset cycle.
    always_comb begin
        ctrl_out = rst ? '0 : ctrl_raw;
        imm_out  = rst ? 3'b000 : imm_src_of(bus.Op);
    end

    assign bus.PCWrite    = ctrl_out.pc_write;
    assign bus.AdrSrc     = ctrl_out.adr_src;
    assign bus.MemWrite   = ctrl_out.mem_write;
    assign bus.IRWrite    = ctrl_out.ir_write;
    assign bus.RegWrite   = ctrl_out.reg_write;
    assign bus.ResultSrc  = ctrl_out.result_src;
    assign bus.ALUSrcA    = ctrl_out.alu_src_a;
    assign bus.ALUSrcB    = ctrl_out.alu_src_b;
    assign bus.ALUOp      = ctrl_out.alu_op;
    assign bus.instr_done = ctrl_out.instr_done;
    assign bus.ImmSrc     = imm_out;
`ifdef MFSM_ILLEGAL_TRAP_EN
    assign bus.illegal_op = !rst && (state_q == S_TRAP);
`endif

endmodule
